// File: rtl/dna_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dna_pkg
//  Description : Shared constants and helpers for the DNA search front end:
//                one-hot base codes, controller state encoding and the
//                ASCII-to-base conversion function.
//  Revision    : 1.0 - initial release
// ============================================================================
package dna_pkg;

    // One-hot base codes; N is the wildcard that matches every base
    localparam logic [3:0] BP_A = 4'b1000;
    localparam logic [3:0] BP_C = 4'b0100;
    localparam logic [3:0] BP_G = 4'b0010;
    localparam logic [3:0] BP_T = 4'b0001;
    localparam logic [3:0] BP_N = 4'b1111;

    // One-hot controller states
    localparam logic [5:0] c_IDLE      = 6'b000001;
    localparam logic [5:0] c_ISSUE     = 6'b000010;
    localparam logic [5:0] c_WAIT_LOW  = 6'b000100;
    localparam logic [5:0] c_WAIT_HIGH = 6'b001000;
    localparam logic [5:0] c_REPORT    = 6'b010000;
    localparam logic [5:0] c_FINISH    = 6'b100000;

    // Returns {code, bad}; unknown characters pack as 0000 with bad set
    function automatic logic [4:0] ascii_to_bp(input logic [7:0] ch);
        logic [4:0] w_res;
        case (ch)
            8'h41, 8'h61: w_res = {BP_A, 1'b0};
            8'h43, 8'h63: w_res = {BP_C, 1'b0};
            8'h47, 8'h67: w_res = {BP_G, 1'b0};
            8'h54, 8'h74: w_res = {BP_T, 1'b0};
            8'h4E, 8'h6E: w_res = {BP_N, 1'b0};
            default:      w_res = {4'b0000, 1'b1};
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dna_char_packer.sv
`default_nettype none
// ============================================================================
//  Module      : dna_char_packer
//  Description : Shifts 4-bit base codes into a sequence register, first base
//                ending in the top nibble. Counts bases up to SEQ_SIZE/4 and
//                flags bytes offered once the register is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module dna_char_packer #(
    parameter int SEQ_SIZE = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    input  logic                load,
    input  logic [3:0]          code,
    output logic [SEQ_SIZE-1:0] seq,
    output logic                full,
    output logic                overflow
);

    localparam int               c_BASES = SEQ_SIZE / 4;
    localparam int               c_CNT_W = $clog2(c_BASES + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(c_BASES);

    logic [SEQ_SIZE-1:0] r_seq;
    logic [c_CNT_W-1:0]  r_cnt;

    // Shift in a new base unless full; clear empties the register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_seq <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_seq <= '0;
            r_cnt <= '0;
        end else if (load && (r_cnt != c_FULL)) begin
            r_seq <= {r_seq[SEQ_SIZE-5:0], code};
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign seq      = r_seq;
    assign full     = (r_cnt == c_FULL);
    assign overflow = load & full;

endmodule
`default_nettype wire

// File: rtl/dna_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dna_search_ctrl
//  Description : Packs an ASCII base stream into big/small sequences, then
//                repeatedly drives the searcher START/DONE handshake to list
//                every match location on a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dna_search_ctrl
    import dna_pkg::*;
#(
    parameter int BIG_SEQ_SIZE            = 32,
    parameter int SMALL_SEQ_SIZE          = 8,
    parameter int OUTER_LOCATION_NUM_SIZE = 5,
    parameter int MATCH_CNT_W             = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_data,
    input  logic                               in_sel,
    input  logic                               clear,
    input  logic                               go,
    output logic                               busy,
    output logic                               fin,
    output logic [MATCH_CNT_W-1:0]             match_count,
    output logic [2:0]                         err,
    output logic                               srch_start,
    output logic [BIG_SEQ_SIZE-1:0]            srch_big_seq,
    output logic [SMALL_SEQ_SIZE-1:0]          srch_small_seq,
    output logic [OUTER_LOCATION_NUM_SIZE-1:0] srch_start_index,
    input  logic                               srch_done,
    input  logic                               srch_found,
    input  logic [OUTER_LOCATION_NUM_SIZE-1:0] srch_location,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [OUTER_LOCATION_NUM_SIZE-1:0] res_loc
);

    localparam int                         c_LW          = OUTER_LOCATION_NUM_SIZE;
    localparam logic [c_LW-1:0]            c_FIRST_INDEX = c_LW'(BIG_SEQ_SIZE - 1);
    localparam logic [c_LW-1:0]            c_MIN_REISSUE = c_LW'(SMALL_SEQ_SIZE + 3);
    localparam logic [c_LW-1:0]            c_STEP        = c_LW'(4);
    localparam logic [MATCH_CNT_W-1:0]     c_CNT_MAX     = '1;

    logic [5:0]             r_state;
    logic [5:0]             w_nxt;
    logic                   r_rdy;
    logic                   r_busy;
    logic                   r_fin;
    logic                   r_start;
    logic                   r_valid;
    logic [c_LW-1:0]        r_index;
    logic [c_LW-1:0]        r_loc;
    logic [MATCH_CNT_W-1:0] r_mcount;
    logic [2:0]             r_err;

    logic                   w_idle;
    logic                   w_clear;
    logic                   w_xfer;
    logic [4:0]             w_bp;
    logic                   w_big_full;
    logic                   w_small_full;
    logic                   w_big_ovf;
    logic                   w_small_ovf;
    logic                   w_go;
    logic                   w_go_ok;
    logic                   w_res_hs;
    logic                   w_reissue;

    assign w_idle    = (r_state == c_IDLE);
    assign w_clear   = clear & w_idle;
    assign in_ready  = r_rdy & ~clear;
    assign w_xfer    = in_valid & in_ready;
    assign w_bp      = ascii_to_bp(in_data);
    assign w_go      = go & w_idle & ~clear;
    assign w_go_ok   = w_go & w_big_full & w_small_full;
    assign w_res_hs  = r_valid & res_ready;
    // Guard keeps location-4 from wrapping and stops once the small
    // sequence can no longer fit below the next start index
    assign w_reissue = (r_loc >= c_MIN_REISSUE);

    dna_char_packer #(.SEQ_SIZE(BIG_SEQ_SIZE)) u_big (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (w_clear),
        .load     (w_xfer & ~in_sel),
        .code     (w_bp[4:1]),
        .seq      (srch_big_seq),
        .full     (w_big_full),
        .overflow (w_big_ovf)
    );

    dna_char_packer #(.SEQ_SIZE(SMALL_SEQ_SIZE)) u_small (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (w_clear),
        .load     (w_xfer & in_sel),
        .code     (w_bp[4:1]),
        .seq      (srch_small_seq),
        .full     (w_small_full),
        .overflow (w_small_ovf)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= c_IDLE;
        else      r_state <= w_nxt;
    end

    // Next-state decode
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            c_IDLE:      if (w_go_ok) w_nxt = c_ISSUE;
            c_ISSUE:     w_nxt = c_WAIT_LOW;
            c_WAIT_LOW:  if (!srch_done) w_nxt = c_WAIT_HIGH;
            c_WAIT_HIGH: if (srch_done) w_nxt = srch_found ? c_REPORT : c_FINISH;
            c_REPORT:    if (res_ready) w_nxt = w_reissue ? c_ISSUE : c_FINISH;
            c_FINISH:    w_nxt = c_IDLE;
            default:     w_nxt = c_IDLE;
        endcase
    end

    // Registered handshake/status outputs derived from the next state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_start <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_rdy   <= (w_nxt == c_IDLE);
            r_busy  <= (w_nxt != c_IDLE);
            r_fin   <= (w_nxt == c_FINISH);
            r_start <= (w_nxt == c_ISSUE);
            r_valid <= (w_nxt == c_REPORT);
        end
    end

    // Search index, captured location and saturating match counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_index  <= '0;
            r_loc    <= '0;
            r_mcount <= '0;
        end else begin
            if (w_go_ok) begin
                r_index  <= c_FIRST_INDEX;
                r_mcount <= '0;
            end
            if ((r_state == c_WAIT_HIGH) && srch_done)
                r_loc <= srch_location;
            if ((r_state == c_REPORT) && w_res_hs) begin
                if (r_mcount != c_CNT_MAX) r_mcount <= r_mcount + MATCH_CNT_W'(1);
                if (w_reissue) r_index <= r_loc - c_STEP;
            end
        end
    end

    // Sticky error flags {incomplete, overflow, bad_char}
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err <= '0;
        end else if (w_clear) begin
            r_err <= '0;
        end else begin
            if (w_xfer && w_bp[0])           r_err[0] <= 1'b1;
            if (w_big_ovf || w_small_ovf)    r_err[1] <= 1'b1;
            if (w_go && !(w_big_full && w_small_full)) r_err[2] <= 1'b1;
        end
    end

    assign busy             = r_busy;
    assign fin              = r_fin;
    assign match_count      = r_mcount;
    assign err              = r_err;
    assign srch_start       = r_start;
    assign srch_start_index = r_index;
    assign res_valid        = r_valid;
    assign res_loc          = r_loc;

endmodule
`default_nettype wire

// File: tb/tb_dna_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dna_search_ctrl
//  Description : Directed bench for dna_search_ctrl with a behavioural
//                searcher model (programmable DONE latency and results).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dna_search_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_sel = 1'b0;
    logic       clear = 1'b0;
    logic       go = 1'b0;
    logic       busy;
    logic       fin;
    logic [3:0] match_count;
    logic [2:0] err;
    logic       srch_start;
    logic [31:0] srch_big_seq;
    logic [7:0] srch_small_seq;
    logic [4:0] srch_start_index;
    logic       srch_done = 1'b0;
    logic       srch_found = 1'b0;
    logic [4:0] srch_location = 5'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [4:0] res_loc;

    int n_total = 0;
    int n_bad   = 0;

    // Searcher model state
    int         m_starts = 0;
    int         m_idx = 0;
    int         m_cnt = 0;
    int         m_lat = 2;
    logic       m_busy = 1'b0;
    logic       m_tbl_found [0:3];
    logic [4:0] m_tbl_loc   [0:3];

    dna_search_ctrl dut (
        .CLK              (CLK),
        .RST              (RST),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_sel           (in_sel),
        .clear            (clear),
        .go               (go),
        .busy             (busy),
        .fin              (fin),
        .match_count      (match_count),
        .err              (err),
        .srch_start       (srch_start),
        .srch_big_seq     (srch_big_seq),
        .srch_small_seq   (srch_small_seq),
        .srch_start_index (srch_start_index),
        .srch_done        (srch_done),
        .srch_found       (srch_found),
        .srch_location    (srch_location),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_loc          (res_loc)
    );

    always #5 CLK = ~CLK;

    // Searcher model: DONE keeps its old value the cycle after START, drops,
    // then rises after m_lat cycles with the programmed result
    always @(posedge CLK) begin
        if (srch_start) begin
            m_busy   <= 1'b1;
            m_cnt    <= m_lat;
            m_idx    <= m_starts;
            m_starts <= m_starts + 1;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                srch_done     <= 1'b1;
                srch_found    <= m_tbl_found[m_idx];
                srch_location <= m_tbl_loc[m_idx];
                m_busy        <= 1'b0;
            end else begin
                srch_done <= 1'b0;
                m_cnt     <= m_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic sel);
        in_valid = 1'b1;
        in_data  = ch;
        in_sel   = sel;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input logic sel);
        for (int i = 0; i < s.len(); i++) send(s[i], sel);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_res(input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        check("res_valid_timeout", {31'b0, res_valid}, 32'd1);
    endtask

    initial begin
        m_tbl_found[0] = 1'b1; m_tbl_loc[0] = 5'd19;
        m_tbl_found[1] = 1'b1; m_tbl_loc[1] = 5'd7;
        m_tbl_found[2] = 1'b1; m_tbl_loc[2] = 5'd19;
        m_tbl_found[3] = 1'b0; m_tbl_loc[3] = 5'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {29'b0, err}, 32'd0);
        check("rst_big", srch_big_seq, 32'd0);
        check("rst_outs", {24'b0, srch_start, res_valid, fin, res_loc}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Packing
        send_str("GATTACAG", 1'b0);
        send_str("ta", 1'b1);
        check("pack_big", srch_big_seq, 32'h28118482);
        check("pack_small", {24'b0, srch_small_seq}, 32'h18);
        check("pack_err", {29'b0, err}, 32'd0);

        // Multi-match run with result backpressure
        pulse_go();
        check("go_start", {31'b0, srch_start}, 32'd1);
        check("go_busy", {31'b0, busy}, 32'd1);
        check("idx0", {27'b0, srch_start_index}, 32'd31);
        check("go_in_ready", {31'b0, in_ready}, 32'd0);
        wait_res(30);
        check("loc0", {27'b0, res_loc}, 32'd19);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'b0, res_valid}, 32'd1);
            check("bp_loc", {27'b0, res_loc}, 32'd19);
            check("bp_nostart", {31'b0, srch_start}, 32'd0);
            check("bp_starts", m_starts, 32'd1);
        end
        res_ready = 1'b1;
        tick();
        check("hs_start", {31'b0, srch_start}, 32'd1);
        check("idx1", {27'b0, srch_start_index}, 32'd15);
        check("hs_count", {28'b0, match_count}, 32'd1);
        check("hs_valid_drop", {31'b0, res_valid}, 32'd0);
        wait_res(30);
        check("loc1", {27'b0, res_loc}, 32'd7);
        tick();
        check("fin_pulse", {31'b0, fin}, 32'd1);
        check("fin_nostart", {31'b0, srch_start}, 32'd0);
        check("fin_count", {28'b0, match_count}, 32'd2);
        tick();
        res_ready = 1'b0;
        check("fin_drop", {31'b0, fin}, 32'd0);
        check("end_busy", {31'b0, busy}, 32'd0);
        check("end_starts", m_starts, 32'd2);

        // Bad, wildcard and overflow bytes
        pulse_clear();
        check("clr_big", srch_big_seq, 32'd0);
        send("X", 1'b0);
        send("n", 1'b0);
        send_str("AAAAAA", 1'b0);
        check("bad_err", {29'b0, err}, 32'd1);
        send("C", 1'b0);
        check("ovf_big", srch_big_seq, 32'h0F888888);
        check("ovf_err", {29'b0, err}, 32'd3);

        // Incomplete load: small sequence empty
        pulse_go();
        check("inc_err", {29'b0, err}, 32'd7);
        check("inc_start", {31'b0, srch_start}, 32'd0);
        check("inc_busy", {31'b0, busy}, 32'd0);
        tick();
        check("inc_starts", m_starts, 32'd2);
        pulse_clear();
        check("clr_err", {29'b0, err}, 32'd0);

        // Reset mid-run while waiting for DONE
        send_str("GATTACAG", 1'b0);
        send_str("ta", 1'b1);
        m_lat = 10;
        pulse_go();
        check("r6_start", {31'b0, srch_start}, 32'd1);
        repeat (4) tick();
        RST = 1'b0;
        #1;
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_in_ready", {31'b0, in_ready}, 32'd0);
        check("mr_idx", {27'b0, srch_start_index}, 32'd0);
        check("mr_big", srch_big_seq, 32'd0);
        check("mr_small", {24'b0, srch_small_seq}, 32'd0);
        check("mr_outs", {20'b0, srch_start, res_valid, fin, err, match_count, 1'b0}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        check("mr_rel_ready", {31'b0, in_ready}, 32'd1);
        send("G", 1'b0);
        check("mr_pack", srch_big_seq, 32'h2);
        pulse_go();
        check("mr_empty_err", {29'b0, err}, 32'd4);
        check("mr_nostart", {31'b0, srch_start}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
